// File: rtl/vc_arb_pkg.sv
// ---------------------------------------------------------------------------
// vc_arb_pkg : shared encodings for the VC0/VC1 mux arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vc_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_VC0   = 2'b01,
    ARB_VC1   = 2'b10,
    ARB_STALL = 2'b11
  } arb_state_t;

  localparam logic SEL_VC0 = 1'b0;
  localparam logic SEL_VC1 = 1'b1;

  localparam int DEFAULT_WEIGHT_VC0 = 4;

endpackage : vc_arb_pkg

`default_nettype wire

// File: rtl/wrr_burst_counter.sv
// ---------------------------------------------------------------------------
// wrr_burst_counter : VC0 burst counter, saturating increment / clear / hold
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrr_burst_counter #(
  parameter int CNT_W      = 3,
  parameter int WEIGHT_VC0 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] c_WEIGHT = CNT_W'(WEIGHT_VC0);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment; the two are mutually exclusive from the grant logic anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_WEIGHT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : wrr_burst_counter

`default_nettype wire

// File: rtl/vc_mux_arbiter.sv
// ---------------------------------------------------------------------------
// vc_mux_arbiter : weighted round-robin pop control for the VC0/VC1 2:1 mux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vc_mux_arbiter
  import vc_arb_pkg::*;
#(
  parameter int NUM_DST    = 4,
  parameter int WEIGHT_VC0 = DEFAULT_WEIGHT_VC0,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               vc0_empty,
  input  logic               vc1_empty,
  input  logic [NUM_DST-1:0] dst_almost_full,
  output logic               pop_vc0,
  output logic               pop_vc1,
  output logic               selector,
  output logic               valid_out,
  output logic [1:0]         arb_state
);

  localparam logic [CNT_W-1:0] c_WEIGHT = CNT_W'(WEIGHT_VC0);

  logic             w_stall;
  logic             w_pop_vc0;
  logic             w_pop_vc1;
  logic [CNT_W-1:0] w_cnt;

  logic             r_selector;
  logic             r_valid;
  arb_state_t       r_state;

  assign w_stall = ~enable | (|dst_almost_full);

  // VC0 keeps the grant until its burst quota is used, unless VC1 has nothing to send.
  assign w_pop_vc0 = ~reset & ~w_stall & ~vc0_empty & ((w_cnt < c_WEIGHT) | vc1_empty);
  assign w_pop_vc1 = ~reset & ~w_stall & ~vc1_empty & ~w_pop_vc0;

  wrr_burst_counter #(
    .CNT_W      (CNT_W),
    .WEIGHT_VC0 (WEIGHT_VC0)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_pop_vc0),
    .i_clr (w_pop_vc1),
    .o_cnt (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_selector <= SEL_VC0;
      r_valid    <= 1'b0;
      r_state    <= ARB_IDLE;
    end else begin
      r_valid <= w_pop_vc0 | w_pop_vc1;
      if (w_pop_vc1) begin
        r_selector <= SEL_VC1;
      end else if (w_pop_vc0) begin
        r_selector <= SEL_VC0;
      end
      // A stall with both FIFOs empty is reported as IDLE: nothing was held back.
      if (w_stall && (!vc0_empty || !vc1_empty)) begin
        r_state <= ARB_STALL;
      end else if (w_pop_vc0) begin
        r_state <= ARB_VC0;
      end else if (w_pop_vc1) begin
        r_state <= ARB_VC1;
      end else begin
        r_state <= ARB_IDLE;
      end
    end
  end

  assign pop_vc0   = w_pop_vc0;
  assign pop_vc1   = w_pop_vc1;
  assign selector  = r_selector;
  assign valid_out = r_valid;
  assign arb_state = r_state;

endmodule : vc_mux_arbiter

`default_nettype wire

// File: tb/tb_vc_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_mux_arbiter : directed scenarios plus random traffic vs. a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vc_mux_arbiter;

  localparam int NUM_DST = 4;
  localparam int WEIGHT  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               vc0_empty = 1'b1;
  logic               vc1_empty = 1'b1;
  logic [NUM_DST-1:0] dst_almost_full = '0;
  logic               pop_vc0, pop_vc1, selector, valid_out;
  logic [1:0]         arb_state;

  int total = 0;
  int bad   = 0;

  // Reference model: streak of consecutive VC0 grants plus last-cycle outcome.
  int         m_streak = 0;
  logic       m_sel    = 1'b0;
  logic       m_valid  = 1'b0;
  logic [1:0] m_state  = 2'd0;
  logic [1:0] exp_pop;   // {vc1, vc0}
  logic [1:0] act_pop;

  vc_mux_arbiter #(
    .NUM_DST    (NUM_DST),
    .WEIGHT_VC0 (WEIGHT),
    .CNT_W      (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .vc0_empty       (vc0_empty),
    .vc1_empty       (vc1_empty),
    .dst_almost_full (dst_almost_full),
    .pop_vc0         (pop_vc0),
    .pop_vc1         (pop_vc1),
    .selector        (selector),
    .valid_out       (valid_out),
    .arb_state       (arb_state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_grant(input logic rst, en, e0, e1,
                                           input logic [NUM_DST-1:0] af, input int streak);
    logic blocked;
    blocked = rst || !en || (af != '0);
    if (blocked) return 2'b00;
    if (!e0 && (streak < WEIGHT || e1)) return 2'b01;
    if (!e1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic ref_advance(input logic rst, en, e0, e1,
                             input logic [NUM_DST-1:0] af, input logic [1:0] g);
    logic stalled;
    stalled = !en || (af != '0);
    if (rst) begin
      m_streak = 0; m_sel = 1'b0; m_valid = 1'b0; m_state = 2'd0;
    end else begin
      m_valid = (g != 2'b00);
      if (g == 2'b10) begin
        m_sel = 1'b1; m_streak = 0;
      end else if (g == 2'b01) begin
        m_sel = 1'b0; m_streak = (m_streak + 1 > WEIGHT) ? WEIGHT : m_streak + 1;
      end
      if (stalled && (!e0 || !e1)) m_state = 2'd3;
      else if (g == 2'b01)         m_state = 2'd1;
      else if (g == 2'b10)         m_state = 2'd2;
      else                         m_state = 2'd0;
    end
  endtask

  // Drives one cycle, samples the combinational pops, then the registered outputs after the edge.
  task automatic drive_cycle(input logic rst, en, e0, e1, input logic [NUM_DST-1:0] af);
    @(negedge clk);
    reset = rst; enable = en; vc0_empty = e0; vc1_empty = e1; dst_almost_full = af;
    #1;
    exp_pop = ref_grant(rst, en, e0, e1, af, m_streak);
    act_pop = {pop_vc1, pop_vc0};
    @(posedge clk);
    ref_advance(rst, en, e0, e1, af, exp_pop);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
      total++; if (act_pop !== 2'b00) begin bad++; $display("FAIL reset_pop[%0d]: got %b want 00", i, act_pop); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_out); end
      total++; if (selector !== 1'b0) begin bad++; $display("FAIL reset_sel[%0d]: got %b want 0", i, selector); end
      total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL reset_state[%0d]: got %0d want 0", i, arb_state); end
    end
  endtask

  task automatic test_wrr_pattern();
    logic [1:0] ep;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
      ep = (i % 5 == 4) ? 2'b10 : 2'b01;
      total++; if (act_pop !== ep) begin bad++; $display("FAIL wrr_pop[%0d]: got %b want %b", i, act_pop, ep); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL wrr_valid[%0d]: got %b want 1", i, valid_out); end
      total++; if (selector !== ep[1]) begin bad++; $display("FAIL wrr_sel[%0d]: got %b want %b", i, selector, ep[1]); end
      total++; if (arb_state !== ep) begin bad++; $display("FAIL wrr_state[%0d]: got %0d want %0d", i, arb_state, ep); end
    end
  endtask

  task automatic test_vc1_only();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
      total++; if (act_pop !== 2'b10) begin bad++; $display("FAIL vc1only_pop[%0d]: got %b want 10", i, act_pop); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL vc1only_valid[%0d]: got %b want 1", i, valid_out); end
      total++; if (selector !== 1'b1) begin bad++; $display("FAIL vc1only_sel[%0d]: got %b want 1", i, selector); end
      total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL vc1only_state[%0d]: got %0d want 2", i, arb_state); end
    end
  endtask

  task automatic test_stall();
    logic [1:0] ep [0:6];
    logic       ev [0:6];
    logic [1:0] est[0:6];
    ep  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    ev  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    est = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, (i == 2 || i == 3) ? 4'b0100 : 4'b0000);
      total++; if (act_pop !== ep[i]) begin bad++; $display("FAIL stall_pop[%0d]: got %b want %b", i, act_pop, ep[i]); end
      total++; if (valid_out !== ev[i]) begin bad++; $display("FAIL stall_valid[%0d]: got %b want %b", i, valid_out, ev[i]); end
      total++; if (selector !== ep[i][1] && i != 2 && i != 3) begin bad++; $display("FAIL stall_sel[%0d]: got %b want %b", i, selector, ep[i][1]); end
      total++; if (arb_state !== est[i]) begin bad++; $display("FAIL stall_state[%0d]: got %0d want %0d", i, arb_state, est[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] ep [0:7];
    ep = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i == 2, 1'b1, 1'b0, 1'b0, '0);
      total++; if (act_pop !== ep[i]) begin bad++; $display("FAIL rstmid_pop[%0d]: got %b want %b", i, act_pop, ep[i]); end
      total++; if (valid_out !== (i != 2)) begin bad++; $display("FAIL rstmid_valid[%0d]: got %b want %b", i, valid_out, i != 2); end
      total++; if (selector !== ep[i][1]) begin bad++; $display("FAIL rstmid_sel[%0d]: got %b want %b", i, selector, ep[i][1]); end
      total++; if (arb_state !== ep[i]) begin bad++; $display("FAIL rstmid_state[%0d]: got %0d want %0d", i, arb_state, ep[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ep;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, i < 6, '0);
      ep = (i == 6 || i == 11) ? 2'b10 : 2'b01;
      total++; if (act_pop !== ep) begin bad++; $display("FAIL sat_pop[%0d]: got %b want %b", i, act_pop, ep); end
      total++; if (arb_state !== ep) begin bad++; $display("FAIL sat_state[%0d]: got %0d want %0d", i, arb_state, ep); end
    end
  endtask

  task automatic test_empty();
    logic held;
    held = m_sel;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, (i == 3) ? 4'b1000 : 4'b0000);
      total++; if (act_pop !== 2'b00) begin bad++; $display("FAIL empty_pop[%0d]: got %b want 00", i, act_pop); end
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL empty_valid[%0d]: got %b want 0", i, valid_out); end
      total++; if (selector !== held) begin bad++; $display("FAIL empty_sel[%0d]: got %b want %b", i, selector, held); end
      total++; if (arb_state !== 2'd0) begin bad++; $display("FAIL empty_state[%0d]: got %0d want 0", i, arb_state); end
    end
  endtask

  task automatic test_enable_low();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, !(i == 2 || i == 3), 1'b0, 1'b0, '0);
      total++; if (act_pop !== exp_pop) begin bad++; $display("FAIL en_pop[%0d]: got %b want %b", i, act_pop, exp_pop); end
      total++; if (arb_state !== m_state) begin bad++; $display("FAIL en_state[%0d]: got %0d want %0d", i, arb_state, m_state); end
      total++; if (valid_out !== m_valid) begin bad++; $display("FAIL en_valid[%0d]: got %b want %b", i, valid_out, m_valid); end
    end
  endtask

  task automatic test_random();
    logic rst, en, e0, e1;
    logic [NUM_DST-1:0] af;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 25) == 0;
      en  = ($urandom % 8) != 0;
      e0  = ($urandom % 3) == 0;
      e1  = ($urandom % 3) == 0;
      af  = (($urandom % 6) == 0) ? NUM_DST'($urandom) : '0;
      drive_cycle(rst, en, e0, e1, af);
      total++; if (act_pop !== exp_pop) begin bad++; $display("FAIL rnd_pop[%0d]: got %b want %b", i, act_pop, exp_pop); end
      total++; if (valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, valid_out, m_valid); end
      total++; if (selector !== m_sel) begin bad++; $display("FAIL rnd_sel[%0d]: got %b want %b", i, selector, m_sel); end
      total++; if (arb_state !== m_state) begin bad++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, arb_state, m_state); end
    end
  endtask

  initial begin
    test_reset();
    test_wrr_pattern();
    test_vc1_only();
    test_stall();
    test_reset_mid_burst();
    test_saturation();
    test_empty();
    test_enable_low();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vc_mux_arbiter

`default_nettype wire
